// File: rtl/bcd_to_decimal_stream_decoder.sv
// Serialises a packed BCD word into one-hot decimal digits, LSD first, over valid/ready.
// Optional leading-zero suppression is enabled by defining BCD_DEC_LZ_SUPPRESS_EN.
module bcd_to_decimal_stream_decoder #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [9:0]            out_y,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  out_err,
  output logic                  err_sticky
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q, state_d;
  logic [4*DIGITS-1:0]   sr_q, sr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [3:0]            nib;
  logic [IDX_W-1:0]      cnt_new;
  logic                  err_new;
  logic                  accept;

  always_comb begin : word_scan
    err_new = 1'b0;
`ifdef BCD_DEC_LZ_SUPPRESS_EN
    cnt_new = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (in_bcd[4*k +: 4] != 4'd0) cnt_new = IDX_W'(k);
    end
`else
    cnt_new = IDX_W'(DIGITS - 1);
`endif
    // Suppressed nibbles are zero, so scanning the whole word matches scanning only emitted ones.
    for (int k = 0; k < DIGITS; k++) begin
      if (in_bcd[4*k +: 4] > 4'd9) err_new = 1'b1;
    end
  end

  assign nib        = sr_q[3:0];
  assign out_valid  = (state_q == SEND);
  assign out_last   = out_valid && (idx_q == cnt_q);
  assign out_err    = out_valid && (nib > 4'd9);
  assign out_y      = (out_valid && (nib <= 4'd9)) ? (10'd1 << nib) : 10'd0;
  assign out_idx    = out_valid ? idx_q : '0;
  assign err_sticky = err_q;
  assign in_ready   = (state_q == IDLE) || (out_last && out_ready);
  assign accept     = in_valid && in_ready;

  always_comb begin : next_state
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (accept) begin
      state_d = SEND;
      sr_d    = in_bcd;
      idx_d   = '0;
      cnt_d   = cnt_new;
      err_d   = err_new;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        state_d = IDLE;
      end else begin
        sr_d  = sr_q >> 4;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_decimal_stream_decoder.sv
// Directed self-checking bench for bcd_to_decimal_stream_decoder (DIGITS=4).
module tb_bcd_to_decimal_stream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_y;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        out_err;
  logic        err_sticky;

  int compared   = 0;
  int mismatched = 0;

  bcd_to_decimal_stream_decoder #(.DIGITS(4), .IDX_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_idx(out_idx), .out_last(out_last), .out_err(out_err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs change here, checks follow #1 later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // v 0..9 expects one-hot 1<<v; v >= 10 expects y=0 with err set.
  task automatic dig(input string tag, input int v, input int idx, input bit last);
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".y"},     32'(out_y),     (v < 10) ? (32'd1 << v) : 32'd0);
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".last"},  32'(out_last),  32'(last));
    chk({tag, ".err"},   32'(out_err),   (v > 9) ? 32'd1 : 32'd0);
  endtask

  task automatic offer(input string tag, input logic [15:0] w);
    next();
    in_valid  = 1'b1;
    in_bcd    = w;
    out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    next();
    in_valid = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    #1;
    chk({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready),   32'd1);
    chk("rst.valid",    32'(out_valid),  32'd0);
    chk("rst.y",        32'(out_y),      32'd0);
    chk("rst.idx",      32'(out_idx),    32'd0);
    chk("rst.last",     32'(out_last),   32'd0);
    chk("rst.err",      32'(out_err),    32'd0);
    chk("rst.sticky",   32'(err_sticky), 32'd0);
    rst = 1'b0;

    // 1: 1234 at full rate
    offer("t1", 16'h1234);
    dig("t1.d0", 4, 0, 0); next();
    dig("t1.d1", 3, 1, 0); next();
    dig("t1.d2", 2, 2, 0); next();
    dig("t1.d3", 1, 3, 1); next();
    idle_chk("t1");

    // 2: 9870 with out_ready pattern 1,0,0,1,0,0,1,...
    offer("t2", 16'h9870);
    out_ready = 1'b1; dig("t2.d0", 0, 0, 0); next();
    out_ready = 1'b0; dig("t2.d1a", 7, 1, 0); next();
    out_ready = 1'b0; dig("t2.d1b", 7, 1, 0); next();
    out_ready = 1'b1; dig("t2.d1c", 7, 1, 0); next();
    out_ready = 1'b0; dig("t2.d2a", 8, 2, 0); next();
    out_ready = 1'b0; dig("t2.d2b", 8, 2, 0); next();
    out_ready = 1'b1; dig("t2.d2c", 8, 2, 0); next();
    out_ready = 1'b0; dig("t2.d3a", 9, 3, 1);
    chk("t2.stall_in_ready", 32'(in_ready), 32'd0); next();
    out_ready = 1'b0; dig("t2.d3b", 9, 3, 1); next();
    out_ready = 1'b1; dig("t2.d3c", 9, 3, 1);
    chk("t2.last_in_ready", 32'(in_ready), 32'd1); next();
    idle_chk("t2");

    // 3: invalid nibble A, sticky error until next accept
    offer("t3", 16'h00A5);
    dig("t3.d0", 5, 0, 0);
    chk("t3.sticky0", 32'(err_sticky), 32'd1); next();
    dig("t3.d1", 10, 1, 0); next();
    dig("t3.d2", 0, 2, 0); next();
    dig("t3.d3", 0, 3, 1); next();
    idle_chk("t3");
    chk("t3.sticky_idle", 32'(err_sticky), 32'd1);
    offer("t3b", 16'h0001);
    dig("t3b.d0", 1, 0, 0);
    chk("t3b.sticky_clr", 32'(err_sticky), 32'd0); next();
    dig("t3b.d1", 0, 1, 0); next();
    dig("t3b.d2", 0, 2, 0); next();
    dig("t3b.d3", 0, 3, 1); next();
    idle_chk("t3b");

    // 4: back-to-back 1111 then 2222 with no bubble
    in_valid = 1'b1; in_bcd = 16'h1111; out_ready = 1'b1;
    #1 chk("t4.acc1", 32'(in_ready), 32'd1);
    next(); in_bcd = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      dig($sformatf("t4.a%0d", i), 1, i, i == 3);
      chk($sformatf("t4.a%0d.in_ready", i), 32'(in_ready), (i == 3) ? 32'd1 : 32'd0);
      next();
      if (i == 3) in_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      dig($sformatf("t4.b%0d", i), 2, i, i == 3);
      chk($sformatf("t4.b%0d.in_ready", i), 32'(in_ready), (i == 3) ? 32'd1 : 32'd0);
      next();
    end
    idle_chk("t4");

    // 5: reset during digit 2 aborts the word
    offer("t5", 16'h5678);
    dig("t5.d0", 8, 0, 0); next();
    dig("t5.d1", 7, 1, 0); next();
    dig("t5.d2", 6, 2, 0);
    rst = 1'b1;
    next();
    chk("t5.rst_valid",  32'(out_valid),  32'd0);
    chk("t5.rst_ready",  32'(in_ready),   32'd1);
    chk("t5.rst_sticky", 32'(err_sticky), 32'd0);
    rst = 1'b0;
    next();
    idle_chk("t5.post");
    offer("t5b", 16'h4321);
    dig("t5b.d0", 1, 0, 0); next();
    dig("t5b.d1", 2, 1, 0); next();
    dig("t5b.d2", 3, 2, 0); next();
    dig("t5b.d3", 4, 3, 1); next();
    idle_chk("t5b");

    // 6: leading zeros
    offer("t6", 16'h0042);
`ifdef BCD_DEC_LZ_SUPPRESS_EN
    dig("t6.d0", 2, 0, 0); next();
    dig("t6.d1", 4, 1, 1); next();
    idle_chk("t6");
    offer("t6z", 16'h0000);
    dig("t6z.d0", 0, 0, 1); next();
    idle_chk("t6z");
`else
    dig("t6.d0", 2, 0, 0); next();
    dig("t6.d1", 4, 1, 0); next();
    dig("t6.d2", 0, 2, 0); next();
    dig("t6.d3", 0, 3, 1); next();
    idle_chk("t6");
    offer("t6z", 16'h0000);
    dig("t6z.d0", 0, 0, 0); next();
    dig("t6z.d1", 0, 1, 0); next();
    dig("t6z.d2", 0, 2, 0); next();
    dig("t6z.d3", 0, 3, 1); next();
    idle_chk("t6z");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
